i2c_cmd_scheduler: RTL and testbench

Command front-end sitting directly upstream of one I2C controller port (start/addr_target/data_send/num_bytes_send/num_bytes_receive). It queues host read/write transactions in a small FIFO, issues them to the controller one at a time, and enforces a bus-free gap between transactions. It tracks controller busy to detect completion and returns per-transaction received data plus status over a valid/ready response channel.

---
 rtl/i2c_cmd_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_i2c_cmd_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_scheduler.sv
// Command queue and sequencer in front of a single I2C controller port.
// Issues one queued transaction at a time, tracks busy for completion, and enforces an idle gap between transactions.
module i2c_cmd_scheduler #(
  parameter int BYTES_SEND_LOG    = 2,
  parameter int BYTES_RECEIVE_LOG = 2,
  parameter int BITS_SEND_MAX     = ((2**BYTES_SEND_LOG)-1) << 3,
  parameter int BITS_RECEIVE_MAX  = ((2**BYTES_RECEIVE_LOG)-1) << 3,
  parameter int FIFO_DEPTH_LOG    = 2,
  parameter int START_HOLD        = 12,
  parameter int GAP_CYCLES        = 25,
  parameter int TIMEOUT_CYCLES    = 65535
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [7:0]                   cmd_addr,
  input  logic [BITS_SEND_MAX-1:0]     cmd_data,
  input  logic [BYTES_SEND_LOG-1:0]    cmd_num_send,
  input  logic [BYTES_RECEIVE_LOG-1:0] cmd_num_receive,
  output logic                         ctrl_start,
  output logic [7:0]                   ctrl_addr,
  output logic [BITS_SEND_MAX-1:0]     ctrl_data_send,
  output logic [BYTES_SEND_LOG-1:0]    ctrl_num_send,
  output logic [BYTES_RECEIVE_LOG-1:0] ctrl_num_receive,
  input  logic                         ctrl_busy,
  input  logic                         ctrl_nack,
  input  logic [BITS_RECEIVE_MAX-1:0]  ctrl_data_rx,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [BITS_RECEIVE_MAX-1:0]  rsp_data,
  output logic [1:0]                   rsp_status,
  output logic [FIFO_DEPTH_LOG:0]      fifo_count
);
  localparam int DEPTH = 2**FIFO_DEPTH_LOG;
  localparam int EW    = 8 + BITS_SEND_MAX + BYTES_SEND_LOG + BYTES_RECEIVE_LOG;
  localparam int GW    = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_LOW, RESP} state_e;

  logic [EW-1:0]               mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FIFO_DEPTH_LOG:0]     count_q;
  state_e                      state_q, state_d;
  logic [15:0]                 to_q, to_d;
  logic [GW-1:0]               gap_q, gap_d;
  logic                        seen_q, seen_d, nack_q, nack_d, start_q, start_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic [BITS_RECEIVE_MAX-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]                  rsp_status_q, rsp_status_d;
  logic [7:0]                  addr_q;
  logic [BITS_SEND_MAX-1:0]    data_q;
  logic [BYTES_SEND_LOG-1:0]   nsend_q;
  logic [BYTES_RECEIVE_LOG-1:0] nrecv_q;
  logic                        push, pop, timed_out, nack_any;

  assign cmd_ready  = (count_q != (FIFO_DEPTH_LOG+1)'(DEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign timed_out  = (to_q == 16'(TIMEOUT_CYCLES));
  assign nack_any   = nack_q | ctrl_nack;

  // Storage needs no reset; occupancy is governed by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_addr, cmd_data, cmd_num_send, cmd_num_receive};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      to_q         <= '0;
      gap_q        <= '0;
      seen_q       <= 1'b0;
      nack_q       <= 1'b0;
      start_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_status_q <= '0;
      {addr_q, data_q, nsend_q, nrecv_q} <= '0;
    end else begin
      state_q      <= state_d;
      to_q         <= to_d;
      gap_q        <= gap_d;
      seen_q       <= seen_d;
      nack_q       <= nack_d;
      start_q      <= start_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
      if (pop) {addr_q, data_q, nsend_q, nrecv_q} <= mem_q[rd_ptr_q];
    end
  end

  always_comb begin
    state_d      = state_q;
    to_d         = to_q;
    gap_d        = gap_q;
    seen_d       = seen_q;
    nack_d       = nack_q;
    start_d      = start_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    pop          = 1'b0;
    case (state_q)
      IDLE: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else if (count_q != '0) begin
          pop     = 1'b1;
          state_d = START;
          start_d = 1'b1;
          to_d    = '0;
          seen_d  = 1'b0;
          nack_d  = 1'b0;
        end
      end
      START: begin
        to_d   = to_q + 16'd1;
        nack_d = nack_any;
        if (timed_out) begin
          start_d      = 1'b0;
          state_d      = RESP;
          rsp_valid_d  = 1'b1;
          rsp_data_d   = '0;
          rsp_status_d = 2'b10;
        end else if (ctrl_busy) begin
          seen_d  = 1'b1;
          start_d = 1'b0;
          state_d = WAIT_LOW;
        end else if (to_q == 16'(START_HOLD - 1)) begin
          // Give up holding start; a later busy pulse still completes normally.
          start_d = 1'b0;
          state_d = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        to_d   = to_q + 16'd1;
        nack_d = nack_any;
        if (ctrl_busy) seen_d = 1'b1;
        if (timed_out) begin
          state_d      = RESP;
          rsp_valid_d  = 1'b1;
          rsp_data_d   = '0;
          rsp_status_d = 2'b10;
        end else if (seen_q && !ctrl_busy) begin
          state_d      = RESP;
          rsp_valid_d  = 1'b1;
          rsp_status_d = nack_any ? 2'b01 : 2'b00;
          rsp_data_d   = (addr_q[0] && !nack_any && nrecv_q != '0) ? ctrl_data_rx : '0;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d  = 1'b0;
          rsp_data_d   = '0;
          rsp_status_d = '0;
          gap_d        = GW'(GAP_CYCLES);
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ctrl_start       = start_q;
  assign ctrl_addr        = addr_q;
  assign ctrl_data_send   = data_q;
  assign ctrl_num_send    = nsend_q;
  assign ctrl_num_receive = nrecv_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_data         = rsp_data_q;
  assign rsp_status       = rsp_status_q;
  assign fifo_count       = count_q;
endmodule

// File: tb/tb_i2c_cmd_scheduler.sv
// Bench for i2c_cmd_scheduler: table of single transactions plus hand-written
// sequences; expected responses queued at push and compared at acceptance.
module tb_i2c_cmd_scheduler;
  localparam int GAP = 25;
  localparam int HOLD = 12;
  localparam int TMO = 65535;

  logic        clk, rst;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_addr;
  logic [23:0] cmd_data;
  logic [1:0]  cmd_num_send, cmd_num_receive;
  logic        ctrl_start;
  logic [7:0]  ctrl_addr;
  logic [23:0] ctrl_data_send;
  logic [1:0]  ctrl_num_send, ctrl_num_receive;
  logic        ctrl_busy, ctrl_nack;
  logic [23:0] ctrl_data_rx;
  logic        rsp_valid, rsp_ready;
  logic [23:0] rsp_data;
  logic [1:0]  rsp_status;
  logic [2:0]  fifo_count;

  i2c_cmd_scheduler dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_num_send(cmd_num_send), .cmd_num_receive(cmd_num_receive),
    .ctrl_start(ctrl_start), .ctrl_addr(ctrl_addr), .ctrl_data_send(ctrl_data_send),
    .ctrl_num_send(ctrl_num_send), .ctrl_num_receive(ctrl_num_receive),
    .ctrl_busy(ctrl_busy), .ctrl_nack(ctrl_nack), .ctrl_data_rx(ctrl_data_rx),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_status(rsp_status), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct { logic [23:0] data; logic [1:0] status; } rsp_t;
  typedef struct {
    logic [7:0] addr; logic [23:0] data; logic [1:0] ns; logic [1:0] nr;
    int busy_len; logic [23:0] rx; bit nack; int hold;
    logic [23:0] exp_data; logic [1:0] exp_status;
  } vec_t;

  rsp_t sb[$];
  vec_t vecs[5];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic [7:0] a, input logic [23:0] d, input logic [1:0] ns,
                          input logic [1:0] nr, input bit track,
                          input logic [23:0] ed, input logic [1:0] es);
    bit acc;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = a; cmd_data = d; cmd_num_send = ns; cmd_num_receive = nr;
    acc = cmd_ready;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (acc && track) sb.push_back('{ed, es});
  endtask

  task automatic wait_start();
    int n = 0;
    while (ctrl_start !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    check("ctrl_start seen", {31'b0, ctrl_start}, 32'd1);
  endtask

  task automatic finish_busy(input int len, input logic [23:0] rx, input bit nack);
    ctrl_busy = 1'b1;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (i == 0) check("start drops after busy", {31'b0, ctrl_start}, 32'd0);
      ctrl_nack = nack && (i == len / 2);
    end
    ctrl_nack = 1'b0;
    ctrl_data_rx = rx;
    ctrl_busy = 1'b0;
    @(negedge clk);
    ctrl_data_rx = 24'hBAD0BA;
  endtask

  task automatic get_rsp(input int hold);
    int n = 0;
    rsp_t e;
    while (rsp_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check("rsp_valid", {31'b0, rsp_valid}, 32'd1);
    if (rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected response: data %0h status %0h, none queued", rsp_data, rsp_status);
      end else begin
        e = sb.pop_front();
        check("rsp_data", {8'b0, rsp_data}, {8'b0, e.data});
        check("rsp_status", {30'b0, rsp_status}, {30'b0, e.status});
        for (int i = 0; i < hold; i++) begin
          @(negedge clk);
          check("held rsp_valid", {31'b0, rsp_valid}, 32'd1);
          check("held rsp_data", {8'b0, rsp_data}, {8'b0, e.data});
          check("held rsp_status", {30'b0, rsp_status}, {30'b0, e.status});
          check("no start while held", {31'b0, ctrl_start}, 32'd0);
        end
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
    end
  endtask

  initial begin
    #(20 * 100000);
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int n, h, total, bad;
    vecs[0] = '{8'h8E, 24'hCAF1AF, 2'd3, 2'd0, 2000, 24'h000000, 1'b0, 0,  24'h000000, 2'b00};
    vecs[1] = '{8'h9F, 24'h000000, 2'd0, 2'd2, 40,   24'h00A55A, 1'b0, 10, 24'h00A55A, 2'b00};
    vecs[2] = '{8'h51, 24'h000000, 2'd0, 2'd0, 30,   24'h123456, 1'b0, 0,  24'h000000, 2'b00};
    vecs[3] = '{8'h62, 24'h000000, 2'd0, 2'd0, 15,   24'hFFFFFF, 1'b0, 0,  24'h000000, 2'b00};
    vecs[4] = '{8'h73, 24'h000000, 2'd0, 2'd3, 50,   24'h778899, 1'b1, 0,  24'h000000, 2'b01};

    rst = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0; cmd_num_send = '0;
    cmd_num_receive = '0; ctrl_busy = 1'b0; ctrl_nack = 1'b0; ctrl_data_rx = '0; rsp_ready = 1'b0;
    #1;
    check("reset cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("reset ctrl_start", {31'b0, ctrl_start}, 32'd0);
    check("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset fifo_count", {29'b0, fifo_count}, 32'd0);
    check("reset ctrl_addr", {24'b0, ctrl_addr}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Table of single transactions.
    for (int i = 0; i < 5; i++) begin
      push_cmd(vecs[i].addr, vecs[i].data, vecs[i].ns, vecs[i].nr, 1'b1,
               vecs[i].exp_data, vecs[i].exp_status);
      if (i == 0) begin
        check("start low at push", {31'b0, ctrl_start}, 32'd0);
        @(negedge clk);
        check("start 1 cycle after push", {31'b0, ctrl_start}, 32'd1);
      end
      wait_start();
      check("ctrl_addr", {24'b0, ctrl_addr}, {24'b0, vecs[i].addr});
      check("ctrl_data_send", {8'b0, ctrl_data_send}, {8'b0, vecs[i].data});
      check("ctrl_num_send", {30'b0, ctrl_num_send}, {30'b0, vecs[i].ns});
      check("ctrl_num_receive", {30'b0, ctrl_num_receive}, {30'b0, vecs[i].nr});
      finish_busy(vecs[i].busy_len, vecs[i].rx, vecs[i].nack);
      get_rsp(vecs[i].hold);
    end

    // Back-to-back with gap measurement and NACK on the last command.
    push_cmd(8'h10, 24'h000011, 2'd1, 2'd0, 1'b1, 24'h0, 2'b00);
    wait_start();
    ctrl_busy = 1'b1;
    push_cmd(8'h9E, 24'h0035CF, 2'd2, 2'd0, 1'b1, 24'h0, 2'b00);
    push_cmd(8'hFD, 24'h000000, 2'd0, 2'd1, 1'b1, 24'h0, 2'b01);
    check("b2b fifo_count", {29'b0, fifo_count}, 32'd2);
    repeat (20) @(negedge clk);
    ctrl_busy = 1'b0;
    @(negedge clk);
    get_rsp(0);
    n = 0;
    while (ctrl_start !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("gap to next start", n, GAP + 1);
    check("b2b ctrl_addr", {24'b0, ctrl_addr}, 32'h9E);
    check("b2b ctrl_data_send", {8'b0, ctrl_data_send}, 32'h35CF);
    finish_busy(30, 24'h0, 1'b0);
    get_rsp(0);
    wait_start();
    check("nack ctrl_addr", {24'b0, ctrl_addr}, 32'hFD);
    finish_busy(30, 24'h00BEEF, 1'b1);
    get_rsp(0);

    // FIFO full, refused push, pop-from-full and push+pop at count 3.
    push_cmd(8'h40, 24'h0, 2'd1, 2'd0, 1'b1, 24'h0, 2'b00);
    wait_start();
    ctrl_busy = 1'b1;
    push_cmd(8'h42, 24'h0, 2'd1, 2'd0, 1'b1, 24'h0, 2'b00);
    push_cmd(8'h44, 24'h0, 2'd1, 2'd0, 1'b1, 24'h0, 2'b00);
    push_cmd(8'h46, 24'h0, 2'd1, 2'd0, 1'b1, 24'h0, 2'b00);
    push_cmd(8'h48, 24'h0, 2'd1, 2'd0, 1'b1, 24'h0, 2'b00);
    check("full fifo_count", {29'b0, fifo_count}, 32'd4);
    check("full cmd_ready", {31'b0, cmd_ready}, 32'd0);
    push_cmd(8'h4A, 24'h0, 2'd1, 2'd0, 1'b1, 24'h0, 2'b00);
    check("refused push count", {29'b0, fifo_count}, 32'd4);
    ctrl_busy = 1'b0;
    @(negedge clk);
    get_rsp(0);
    repeat (GAP) @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 8'h4C;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("pop at full, no write-through", {29'b0, fifo_count}, 32'd3);
    check("start on pop from full", {31'b0, ctrl_start}, 32'd1);
    check("pop-from-full addr", {24'b0, ctrl_addr}, 32'h42);
    finish_busy(10, 24'h0, 1'b0);
    get_rsp(0);
    repeat (GAP) @(negedge clk);
    cmd_valid = 1'b1; cmd_addr = 8'h4E;
    sb.push_back('{24'h0, 2'b00});
    @(negedge clk);
    cmd_valid = 1'b0;
    check("push+pop keeps count", {29'b0, fifo_count}, 32'd3);
    check("start on push+pop", {31'b0, ctrl_start}, 32'd1);
    check("push+pop addr", {24'b0, ctrl_addr}, 32'h44);
    finish_busy(10, 24'h0, 1'b0);
    get_rsp(0);
    for (int i = 0; i < 3; i++) begin
      wait_start();
      finish_busy(5, 24'h0, 1'b0);
      get_rsp(0);
    end
    check("drained fifo_count", {29'b0, fifo_count}, 32'd0);

    // Reset while waiting for busy to fall.
    push_cmd(8'h31, 24'h0, 2'd0, 2'd1, 1'b0, 24'h0, 2'b00);
    push_cmd(8'h33, 24'h0, 2'd0, 2'd1, 1'b0, 24'h0, 2'b00);
    wait_start();
    ctrl_busy = 1'b1;
    repeat (3) @(negedge clk);
    check("pre-reset fifo_count", {29'b0, fifo_count}, 32'd1);
    #3 rst = 1'b0;
    #1;
    check("async rst ctrl_start", {31'b0, ctrl_start}, 32'd0);
    check("async rst ctrl_addr", {24'b0, ctrl_addr}, 32'd0);
    check("async rst ctrl_num_receive", {30'b0, ctrl_num_receive}, 32'd0);
    check("async rst fifo_count", {29'b0, fifo_count}, 32'd0);
    check("async rst cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("async rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    ctrl_busy = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || ctrl_start !== 1'b0) bad++;
    end
    check("quiet after reset", bad, 0);

    // Timeout: busy never rises.
    push_cmd(8'h20, 24'h0000AA, 2'd1, 2'd0, 1'b1, 24'h0, 2'b10);
    wait_start();
    h = 0;
    while (ctrl_start === 1'b1 && h < 100) begin @(negedge clk); h++; end
    check("start hold cycles", h, HOLD);
    total = h;
    while (rsp_valid !== 1'b1 && total < 70000) begin @(negedge clk); total++; end
    // Counter is 0 in the first START cycle; it fires when it holds TMO.
    check("timeout latency", total, TMO + 1);
    get_rsp(0);
    check("scoreboard empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
